// File: rtl/kernel_pkg.sv
// Shared kernel-memory definitions: weight/word widths and writer FSM states.
// load_kernel imports the same package so both sides agree on the packed word layout.
package kernel_pkg;
    localparam int WEIGHT_W = 8;
    localparam int TAPS     = 9;
    localparam int COUT_W   = 4;
    localparam int TAP_W    = 4;
    localparam int KWORD_W  = TAPS * WEIGHT_W;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_COLLECT = 2'd1,
        S_WRITE   = 2'd2,
        S_DONE    = 2'd3
    } state_t;
endpackage

// File: rtl/kernel_packer.sv
// Collects TAPS weight bytes into one kernel word, slot k taking beat k.
// word_next shows the word including the byte accepted this cycle, so the writer can register it directly.
module kernel_packer
    import kernel_pkg::*;
(
    input  logic                clk,
    input  logic                rst,
    input  logic                push,
    input  logic [WEIGHT_W-1:0] data,
    output logic                full,
    output logic [KWORD_W-1:0]  word_next
);
    logic [TAP_W-1:0]   tap_cnt_q, tap_cnt_d;
    logic [KWORD_W-1:0] packed_q, packed_d;

    // Slot write and tap counter advance on each accepted byte; both hold across gaps.
    always_comb begin
        packed_d  = packed_q;
        tap_cnt_d = tap_cnt_q;
        full      = 1'b0;
        if (push) begin
            for (int i = 0; i < TAPS; i++) begin
                if (tap_cnt_q == TAP_W'(i)) begin
                    packed_d[i*WEIGHT_W +: WEIGHT_W] = data;
                end else begin
                    packed_d[i*WEIGHT_W +: WEIGHT_W] = packed_q[i*WEIGHT_W +: WEIGHT_W];
                end
            end
            if (tap_cnt_q == TAP_W'(TAPS - 1)) begin
                tap_cnt_d = {TAP_W{1'b0}};
                full      = 1'b1;
            end else begin
                tap_cnt_d = tap_cnt_q + TAP_W'(1);
            end
        end else begin
            packed_d  = packed_q;
            tap_cnt_d = tap_cnt_q;
        end
        word_next = packed_d;
    end

    // Packer state registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            tap_cnt_q <= {TAP_W{1'b0}};
            packed_q  <= {KWORD_W{1'b0}};
        end else begin
            tap_cnt_q <= tap_cnt_d;
            packed_q  <= packed_d;
        end
    end
endmodule

// File: rtl/kernel_writer.sv
// Write side of the kernel weight RAM: streams 9 bytes per output channel, packs them,
// and writes channels 0..NUM_COUT-1 in order before pulsing done.
module kernel_writer
    import kernel_pkg::*;
#(
    parameter int NUM_COUT = 8
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [WEIGHT_W-1:0] in_data,
    input  logic                in_valid,
    output logic                in_ready,
    output logic                wr_en,
    output logic [COUT_W-1:0]   wr_addr,
    output logic [KWORD_W-1:0]  wr_data,
    output logic                busy,
    output logic                done
);
    localparam logic [COUT_W-1:0] LAST_CHAN = COUT_W'(NUM_COUT - 1);

    state_t              state_q, state_d;
    logic [COUT_W-1:0]   chan_q, chan_d;
    logic                in_ready_q, in_ready_d;
    logic                wr_en_q, wr_en_d;
    logic [COUT_W-1:0]   wr_addr_q, wr_addr_d;
    logic [KWORD_W-1:0]  wr_data_q, wr_data_d;
    logic                busy_q, busy_d;
    logic                done_q, done_d;
    logic                push_s;
    logic                full_s;
    logic [KWORD_W-1:0]  word_next_s;

    // in_ready is a flop, so the accept decision never depends combinationally on in_valid.
    assign push_s = in_valid && in_ready_q;

    kernel_packer u_packer (
        .clk       (clk),
        .rst       (rst),
        .push      (push_s),
        .data      (in_data),
        .full      (full_s),
        .word_next (word_next_s)
    );

    // Next-state, channel sequencing and output register inputs.
    always_comb begin
        state_d   = state_q;
        chan_d    = chan_q;
        wr_en_d   = 1'b0;
        wr_addr_d = wr_addr_q;
        wr_data_d = wr_data_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    state_d = S_COLLECT;
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_COLLECT: begin
                if (full_s) begin
                    state_d   = S_WRITE;
                    wr_en_d   = 1'b1;
                    wr_addr_d = chan_q;
                    wr_data_d = word_next_s;
                end else begin
                    state_d = S_COLLECT;
                end
            end
            S_WRITE: begin
                if (chan_q == LAST_CHAN) begin
                    state_d = S_DONE;
                    chan_d  = {COUT_W{1'b0}};
                end else begin
                    state_d = S_COLLECT;
                    chan_d  = chan_q + COUT_W'(1);
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                chan_d  = {COUT_W{1'b0}};
            end
        endcase
        in_ready_d = (state_d == S_COLLECT);
        busy_d     = (state_d != S_IDLE);
        done_d     = (state_d == S_DONE);
    end

    // State, channel counter and registered outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            chan_q     <= {COUT_W{1'b0}};
            in_ready_q <= 1'b0;
            wr_en_q    <= 1'b0;
            wr_addr_q  <= {COUT_W{1'b0}};
            wr_data_q  <= {KWORD_W{1'b0}};
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            chan_q     <= chan_d;
            in_ready_q <= in_ready_d;
            wr_en_q    <= wr_en_d;
            wr_addr_q  <= wr_addr_d;
            wr_data_q  <= wr_data_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign in_ready = in_ready_q;
    assign wr_en    = wr_en_q;
    assign wr_addr  = wr_addr_q;
    assign wr_data  = wr_data_q;
    assign busy     = busy_q;
    assign done     = done_q;
endmodule

// File: tb/tb_kernel_writer.sv
// Directed bench for kernel_writer: a single-channel instance and an eight-channel instance
// share the stimulus; writes are captured into a small RAM model and compared to hand-built words.
module tb_kernel_writer;
    import kernel_pkg::*;

    logic                clk = 1'b0;
    logic                rst, start, in_valid;
    logic [WEIGHT_W-1:0] in_data;

    logic                r1, we1, b1, d1;
    logic [COUT_W-1:0]   wa1;
    logic [KWORD_W-1:0]  wd1;
    logic                r8, we8, b8, d8;
    logic [COUT_W-1:0]   wa8;
    logic [KWORD_W-1:0]  wd8;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt1, wr_cnt8, done_cnt8;
    logic [COUT_W-1:0]  cap_addr8 [0:15];
    logic [KWORD_W-1:0] cap_data8 [0:15];

    always #5 clk = ~clk;

    kernel_writer #(.NUM_COUT(1)) dut1 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r1), .wr_en(we1), .wr_addr(wa1), .wr_data(wd1), .busy(b1), .done(d1)
    );

    kernel_writer #(.NUM_COUT(8)) dut8 (
        .clk(clk), .rst(rst), .start(start), .in_data(in_data), .in_valid(in_valid),
        .in_ready(r8), .wr_en(we8), .wr_addr(wa8), .wr_data(wd8), .busy(b8), .done(d8)
    );

    // Write capture on the falling edge: one entry per wr_en cycle.
    always @(negedge clk) begin
        if (rst) begin
            wr_cnt1   = 0;
            wr_cnt8   = 0;
            done_cnt8 = 0;
        end else begin
            if (we8) begin
                if (wr_cnt8 < 16) begin
                    cap_addr8[wr_cnt8] = wa8;
                    cap_data8[wr_cnt8] = wd8;
                end
                wr_cnt8++;
            end
            if (we1) wr_cnt1++;
            if (d8) done_cnt8++;
        end
    end

    task automatic check_eq(input string tag, input logic [KWORD_W-1:0] got,
                            input logic [KWORD_W-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [KWORD_W-1:0] pack_seq(input logic [7:0] base);
        logic [KWORD_W-1:0] w;
        w = '0;
        for (int k = 0; k < TAPS; k++) w[k*WEIGHT_W +: WEIGHT_W] = base + 8'(k);
        return w;
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    // Present one byte (after gap idle cycles) and hold it until it is accepted.
    task automatic send_byte(input logic [7:0] b, input bit use8, input int gap);
        int n;
        logic rdy;
        in_valid = 1'b0;
        repeat (gap) tick();
        in_data  = b;
        in_valid = 1'b1;
        n   = 0;
        rdy = use8 ? r8 : r1;
        while (rdy !== 1'b1 && n < 40) begin
            tick();
            n++;
            rdy = use8 ? r8 : r1;
        end
        if (n >= 40) check_eq("ready_timeout", {71'd0, rdy}, 72'd1);
        tick();
        in_valid = 1'b0;
    endtask

    task automatic send_chan(input logic [7:0] base, input bit use8);
        for (int k = 0; k < TAPS; k++) send_byte(base + 8'(k), use8, 0);
    endtask

    initial begin
        int n;
        rst = 1'b1; start = 1'b0; in_valid = 1'b0; in_data = 8'd0;

        // Reset values and idle without start
        do_reset();
        check_eq("rst_in_ready", {71'd0, r8}, 72'd0);
        check_eq("rst_wr_en", {71'd0, we8}, 72'd0);
        check_eq("rst_wr_addr", {68'd0, wa8}, 72'd0);
        check_eq("rst_wr_data", wd8, 72'd0);
        check_eq("rst_busy", {71'd0, b8}, 72'd0);
        check_eq("rst_done", {71'd0, d8}, 72'd0);
        repeat (3) tick();
        check_eq("idle_busy", {71'd0, b8}, 72'd0);
        check_eq("idle_ready", {71'd0, r8}, 72'd0);

        // Single channel on the NUM_COUT=1 instance
        pulse_start();
        check_eq("one_ready", {71'd0, r1}, 72'd1);
        send_chan(8'd1, 1'b0);
        check_eq("one_wr_en", {71'd0, we1}, 72'd1);
        check_eq("one_wr_addr", {68'd0, wa1}, 72'd0);
        check_eq("one_wr_data", wd1, 72'h090807060504030201);
        check_eq("one_ready_write", {71'd0, r1}, 72'd0);
        tick();
        check_eq("one_wr_en_drop", {71'd0, we1}, 72'd0);
        check_eq("one_done", {71'd0, d1}, 72'd1);
        check_eq("one_busy_done", {71'd0, b1}, 72'd1);
        check_eq("one_hold_data", wd1, 72'h090807060504030201);
        tick();
        check_eq("one_done_drop", {71'd0, d1}, 72'd0);
        check_eq("one_busy_drop", {71'd0, b1}, 72'd0);
        check_eq("one_wr_cnt", 72'(wr_cnt1), 72'd1);

        // Full eight-channel load, with start pulses while busy and in DONE
        do_reset();
        pulse_start();
        for (int c = 0; c < 8; c++) begin
            for (int k = 0; k < TAPS; k++) begin
                if (c == 3 && k == 4) start = 1'b1;
                send_byte(8'(10*c + k + 1), 1'b1, 0);
                start = 1'b0;
            end
        end
        n = 0;
        while (d8 !== 1'b1 && n < 10) begin
            tick();
            n++;
        end
        check_eq("full_done_seen", {71'd0, d8}, 72'd1);
        pulse_start();
        check_eq("done_start_busy", {71'd0, b8}, 72'd0);
        repeat (12) tick();
        check_eq("after_busy", {71'd0, b8}, 72'd0);
        check_eq("full_wr_cnt", 72'(wr_cnt8), 72'd8);
        check_eq("full_done_cnt", 72'(done_cnt8), 72'd1);
        for (int c = 0; c < 8; c++) begin
            check_eq($sformatf("full_addr%0d", c), {68'd0, cap_addr8[c]}, 72'(c));
            check_eq($sformatf("full_data%0d", c), cap_data8[c], pack_seq(8'(10*c + 1)));
        end

        // Bubbles on in_valid; next byte held valid through the WRITE cycle
        do_reset();
        pulse_start();
        for (int k = 0; k < TAPS; k++) send_byte(8'hA0 + 8'(k), 1'b1, int'($urandom_range(0, 2)));
        check_eq("bub_wr_en", {71'd0, we8}, 72'd1);
        check_eq("bub_ready_write", {71'd0, r8}, 72'd0);
        for (int k = 0; k < TAPS; k++) send_byte(8'hB0 + 8'(k), 1'b1, (k == 0) ? 0 : int'($urandom_range(0, 2)));
        tick();
        check_eq("bub_wr_cnt", 72'(wr_cnt8), 72'd2);
        check_eq("bub_data0", cap_data8[0], 72'hA8A7A6A5A4A3A2A1A0);
        check_eq("bub_data1", cap_data8[1], 72'hB8B7B6B5B4B3B2B1B0);
        check_eq("bub_addr1", {68'd0, cap_addr8[1]}, 72'd1);

        // Reset in the middle of channel 2, then restart from channel 0
        do_reset();
        pulse_start();
        send_chan(8'd1, 1'b1);
        send_chan(8'd11, 1'b1);
        for (int k = 0; k < 5; k++) send_byte(8'(21 + k), 1'b1, 0);
        tick();
        check_eq("mid_wr_cnt", 72'(wr_cnt8), 72'd2);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("mid_busy", {71'd0, b8}, 72'd0);
        check_eq("mid_ready", {71'd0, r8}, 72'd0);
        repeat (3) tick();
        check_eq("mid_no_write", 72'(wr_cnt8), 72'd0);
        pulse_start();
        send_chan(8'h51, 1'b1);
        check_eq("re_wr_en", {71'd0, we8}, 72'd1);
        check_eq("re_wr_addr", {68'd0, wa8}, 72'd0);
        check_eq("re_wr_data", wd8, 72'h595857565554535251);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
